// File: rtl/sha_pad.sv
// SHA-256 message pre-processor: buffers a byte stream into 64-byte blocks and
// appends the 0x80 marker, zero fill and 64-bit big-endian bit length.
//
// state | meaning
// FILL  | accepting message bytes into the buffer at idx
// PAD   | final byte written; place 0x80 and, if it fits, the length
// EMIT  | block presented on m_o until the consumer takes it
// PAD2  | build the extra length-only block (0x80 first if still owed)
module sha_pad #(
    parameter int n = 32,
    parameter int m = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [7:0]   data_i,
    input  logic         valid_i,
    input  logic         last_i,
    output logic         ready_o,
    output logic [n-1:0] m_o [0:m-1],
    output logic         blk_valid_o,
    output logic         blk_last_o,
    input  logic         blk_ready_i
);

    typedef enum logic [1:0] {FILL, PAD, EMIT, PAD2} state_t;

    state_t      state_q, state_d;
    logic [7:0]  blk_buf_q [0:63];
    logic [7:0]  blk_buf_d [0:63];
    logic [5:0]  idx_q, idx_d;
    logic [60:0] cnt_q, cnt_d;
    logic        owe80_q, owe80_d;
    logic        pend2_q, pend2_d;
    logic        last_q, last_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic [63:0] bit_len;

    always_comb begin
        state_d   = state_q;
        blk_buf_d = blk_buf_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        owe80_d   = owe80_q;
        pend2_d   = pend2_q;
        last_d    = last_q;
        bit_len   = {cnt_q, 3'b000};

        case (state_q)
            FILL: begin
                if (valid_i) begin
                    blk_buf_d[idx_q] = data_i;
                    idx_d = idx_q + 6'd1;
                    cnt_d = cnt_q + 61'd1;
                    if (last_i) begin
                        state_d = PAD;
                    end else if (idx_q == 6'd63) begin
                        state_d = EMIT;
                        last_d  = 1'b0;
                    end
                end
            end
            PAD: begin
                // idx now points one past the final byte; 0 means the block filled up.
                // Bytes beyond idx are already zero because the buffer is cleared per block.
                state_d = EMIT;
                if (idx_q == 6'd0) begin
                    owe80_d = 1'b1;
                    pend2_d = 1'b1;
                    last_d  = 1'b0;
                end else if (idx_q <= 6'd55) begin
                    blk_buf_d[idx_q] = 8'h80;
                    for (int b = 0; b < 8; b++) begin
                        blk_buf_d[56+b] = bit_len[8*(7-b) +: 8];
                    end
                    last_d = 1'b1;
                end else begin
                    blk_buf_d[idx_q] = 8'h80;
                    pend2_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            PAD2: begin
                if (owe80_q) begin
                    blk_buf_d[0] = 8'h80;
                end
                for (int b = 0; b < 8; b++) begin
                    blk_buf_d[56+b] = bit_len[8*(7-b) +: 8];
                end
                pend2_d = 1'b0;
                last_d  = 1'b1;
                state_d = EMIT;
            end
            EMIT: begin
                if (blk_ready_i) begin
                    blk_buf_d = '{default: 8'h00};
                    idx_d     = 6'd0;
                    last_d    = 1'b0;
                    state_d   = pend2_q ? PAD2 : FILL;
                    if (last_q) begin
                        cnt_d   = 61'd0;
                        owe80_d = 1'b0;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        ready_d = (state_d == FILL);
        valid_d = (state_d == EMIT);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= FILL;
            blk_buf_q <= '{default: 8'h00};
            idx_q     <= 6'd0;
            cnt_q     <= 61'd0;
            owe80_q   <= 1'b0;
            pend2_q   <= 1'b0;
            last_q    <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_buf_q <= blk_buf_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            owe80_q   <= owe80_d;
            pend2_q   <= pend2_d;
            last_q    <= last_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
        end
    end

    for (genvar w = 0; w < m; w++) begin : g_word
        assign m_o[w] = {blk_buf_q[4*w], blk_buf_q[4*w+1], blk_buf_q[4*w+2], blk_buf_q[4*w+3]};
    end

    assign ready_o     = ready_q;
    assign blk_valid_o = valid_q;
    assign blk_last_o  = last_q;

endmodule

// File: doc/sha_pad.md
# sha_pad

Message pre-processor for the SHA-256 datapath. It accepts a byte stream with valid/ready handshake and applies FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit big-endian message bit length. It emits 512-bit blocks as sixteen 32-bit big-endian words, in the same array form the `sha_256` core takes on `m_i`. It sits directly upstream of `sha_256` and presents one block at a time until the consumer accepts it.

## Interface
- `n`, 32, word width in bits (fixed at 32 for SHA-256).
- `m`, 16, words per block.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-low; one clock, all flops reset on `rst_i`=0.
- `data_i`  in  8  message byte.
- `valid_i`  in  1  `data_i` valid.
- `last_i`  in  1  marks the final byte of the message; qualified by `valid_i`.
- `ready_o`  out  1  byte accepted this cycle when `valid_i`&`ready_o`.
- `m_o`  out  `n` × [0:`m`-1]  block words; `m_o[0]` holds message bytes 0..3, MSB first.
- `blk_valid_o`  out  1  `m_o` holds a complete block.
- `blk_last_o`  out  1  current block is the final block of the message.
- `blk_ready_i`  in  1  consumer accepts the block when `blk_valid_o`&`blk_ready_i`.

## Operation
- Storage:
  - 64-byte buffer.
  - 6-bit byte index `idx`.
  - 61-bit byte counter `cnt`; bit length = `cnt`<<3, and `cnt` wraps mod 2^61.
  - Flag `owe80`, set when 0x80 has not yet been placed.
- FSM states: FILL, PAD, EMIT, PAD2.
- FILL:
  - `ready_o`=1.
  - Each accepted byte is written at `idx`, then `idx`++ and `cnt`++.
  - If `last_i` is set → PAD.
  - Else, if the byte landed at index 63 → EMIT with `blk_last_o`=0.
- PAD is one cycle, entered with final-byte index k:
  - k ≤ 54: write 0x80 at k+1, zeros at k+2..55, length at 56..63 → EMIT, last=1.
  - 55 ≤ k ≤ 62: write 0x80 at k+1, zeros after it → EMIT, last=0, then PAD2.
  - k = 63: buffer is already full → EMIT, last=0, `owe80`=1, then PAD2.
- PAD2 is one cycle:
  - Buffer becomes 0x80 at byte 0 if `owe80`, otherwise zeros.
  - Zeros fill up to byte 55; length goes in 56..63.
  - → EMIT, last=1.
- EMIT:
  - `blk_valid_o`=1 and `ready_o`=0.
  - `m_o` and `blk_last_o` stay stable until `blk_ready_i`.
  - On handshake, clear the buffer and `idx`, then go to PAD2 if a second block is pending, else FILL.
  - After the last block, also clear `cnt` and `owe80`.
- `valid_i` and `last_i` are ignored outside FILL.
- Messages are at least 1 byte long; zero-length messages are not supported.

## Timing
- Reset values: `ready_o`=1 (FILL), `blk_valid_o`=0, `blk_last_o`=0, `m_o` all zero, `idx`=0, `cnt`=0.
- The 64th non-last byte is accepted at edge t; `blk_valid_o`=1 from t+1.
- The last byte is accepted at edge t; PAD occupies t+1 and `blk_valid_o`=1 from t+2.
- Second block: PAD2 occupies the cycle after the first handshake; `blk_valid_o` rises the cycle after that.
- Back-to-back messages: FILL resumes the cycle after the last handshake, and the first byte is accepted there.
- If `blk_ready_i` is held high, `blk_valid_o` is a single-cycle pulse per block.
- Reset mid-operation: the partial block and length are discarded and no block is emitted.
- `m_o` is registered, with no combinational path from `data_i`.

## Test plan
- "abc" (0x61,0x62,0x63 with `last_i` on 0x63):
  - One block, `blk_last_o`=1.
  - `m_o[0]`=0x61626380, `m_o[1..14]`=0, `m_o[15]`=0x00000018.
- 55 bytes of 0x61:
  - One block, `m_o[0..12]`=0x61616161, `m_o[13]`=0x61616180.
  - `m_o[14]`=0, `m_o[15]`=0x000001B8, last=1.
- 56 bytes of 0x61:
  - Block 1 (last=0): `m_o[0..13]`=0x61616161, `m_o[14]`=0x80000000, `m_o[15]`=0.
  - Block 2 (last=1): all zero except `m_o[15]`=0x000001C0.
- 64 bytes of 0x61:
  - Block 1 (last=0): all words 0x61616161.
  - Block 2 (last=1): `m_o[0]`=0x80000000, `m_o[15]`=0x00000200.
- Backpressure: hold `blk_ready_i`=0 for 10 cycles during "abc".
  - `m_o` stays stable and `ready_o`=0 throughout.
  - Exactly one handshake occurs; the next message's first byte is accepted the cycle after it.
- Reset pulse after 20 of 56 bytes, then send "abc":
  - No block appears before the reset.
  - Output matches the "abc" case; length is 0x18, not 0xB8.
